// File: rtl/bf_window_matcher_if.sv
// Bundles the scan control, template input, DRAM window read port and result
// outputs of the 7x7 template matcher.
interface bf_window_matcher_if #(
    parameter int A_WIDTH = 21,
    parameter int MASKLEN = 392,
    parameter int SAD_W   = 14
);
    logic                start;
    logic [MASKLEN-1:0]  template;
    logic                ren;
    logic [A_WIDTH-1:0]  raddr;
    logic [MASKLEN-1:0]  rdata;
    logic                busy;
    logic                done;
    logic [SAD_W-1:0]    best_sad;
    logic [A_WIDTH-1:0]  best_addr;

    modport master (
        input  start, template, rdata,
        output ren, raddr, busy, done, best_sad, best_addr
    );

    modport slave (
        output start, template, rdata,
        input  ren, raddr, busy, done, best_sad, best_addr
    );
endinterface

// File: rtl/bf_window_matcher.sv
// Brute-force 7x7 SAD template matcher: walks every window position in raster
// order through the DRAM window port and keeps the earliest minimum-SAD address.
module bf_window_matcher #(
    parameter int D_WIDTH = 8,
    parameter int A_WIDTH = 21,
    parameter int MASKLEN = 392,
    parameter int IMG_W   = 1280,
    parameter int IMG_H   = 720,
    parameter int WIN     = 7,
    parameter int SAD_W   = 14
) (
    input  logic                 clk,
    input  logic                 rst,
    bf_window_matcher_if.master  bus
);

    localparam int unsigned NPIX = WIN * WIN;
    localparam int X_W = $clog2(IMG_W);
    localparam logic [X_W-1:0]     X_LAST   = X_W'(IMG_W - WIN);
    localparam logic [A_WIDTH-1:0] ROW_LAST = A_WIDTH'((IMG_H - WIN) * IMG_W);
    localparam logic [A_WIDTH-1:0] ROW_STEP = A_WIDTH'(IMG_W);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

    state_t               state;
    logic [X_W-1:0]       x;
    logic [A_WIDTH-1:0]   row_base;

    logic                 v0, v1, v2;
    logic [A_WIDTH-1:0]   tag0, tag1, tag2;
    logic [D_WIDTH-1:0]   ad [NPIX];
    logic [SAD_W-1:0]     sum;
    logic [SAD_W-1:0]     sum_next;

    // Valid bits and address tags travel with the data so P3 ignores idle rdata.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v0   <= 1'b0;
            v1   <= 1'b0;
            v2   <= 1'b0;
            tag0 <= '0;
            tag1 <= '0;
            tag2 <= '0;
        end else begin
            v0   <= bus.ren;
            tag0 <= bus.raddr;
            v1   <= v0;
            tag1 <= tag0;
            v2   <= v1;
            tag2 <= tag1;
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned k = 0; k < NPIX; k++) begin
            ad[k] <= (bus.rdata[MASKLEN-1-D_WIDTH*k -: D_WIDTH] > bus.template[MASKLEN-1-D_WIDTH*k -: D_WIDTH])
                   ? bus.rdata[MASKLEN-1-D_WIDTH*k -: D_WIDTH] - bus.template[MASKLEN-1-D_WIDTH*k -: D_WIDTH]
                   : bus.template[MASKLEN-1-D_WIDTH*k -: D_WIDTH] - bus.rdata[MASKLEN-1-D_WIDTH*k -: D_WIDTH];
        end
        sum <= sum_next;
    end

    always_comb begin
        sum_next = '0;
        for (int unsigned k = 0; k < NPIX; k++) begin
            sum_next = sum_next + SAD_W'(ad[k]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            x             <= '0;
            row_base      <= '0;
            bus.ren       <= 1'b0;
            bus.raddr     <= '0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.best_sad  <= '1;
            bus.best_addr <= '0;
        end else begin
            bus.done <= 1'b0;
            if (v2 && (sum < bus.best_sad)) begin
                bus.best_sad  <= sum;
                bus.best_addr <= tag2;
            end
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        x             <= '0;
                        row_base      <= '0;
                        bus.raddr     <= '0;
                        bus.ren       <= 1'b1;
                        bus.busy      <= 1'b1;
                        bus.best_sad  <= '1;
                        bus.best_addr <= '0;
                        state         <= SCAN;
                    end
                end
                SCAN: begin
                    if (x == X_LAST && row_base == ROW_LAST) begin
                        bus.ren <= 1'b0;
                        state   <= DRAIN;
                    end else if (x == X_LAST) begin
                        x         <= '0;
                        row_base  <= row_base + ROW_STEP;
                        bus.raddr <= row_base + ROW_STEP;
                    end else begin
                        x         <= x + X_W'(1);
                        bus.raddr <= bus.raddr + A_WIDTH'(1);
                    end
                end
                DRAIN: begin
                    // Once P0 and P1 are empty the last position is committing in P3 this edge.
                    if (!v0 && !v1) begin
                        bus.done <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bf_window_matcher.sv
// Self-checking bench for bf_window_matcher on a reduced 24x14 image with a
// behavioural DRAM window model and a brute-force SAD reference.
module tb_bf_window_matcher;

    localparam int W       = 24;
    localparam int H       = 14;
    localparam int A_WIDTH = 21;
    localparam int MASKLEN = 392;
    localparam int SAD_W   = 14;
    localparam int XN      = W - 7 + 1;
    localparam int YN      = H - 7 + 1;
    localparam int NPOS    = XN * YN;
    localparam int LAST_A  = (YN - 1) * W + (XN - 1);

    logic clk = 1'b0;
    logic rst;

    bf_window_matcher_if #(.A_WIDTH(A_WIDTH), .MASKLEN(MASKLEN), .SAD_W(SAD_W)) bus ();

    bf_window_matcher #(
        .D_WIDTH(8), .A_WIDTH(A_WIDTH), .MASKLEN(MASKLEN),
        .IMG_W(W), .IMG_H(H), .WIN(7), .SAD_W(SAD_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    logic [7:0] img [W*H];
    logic [7:0] tpl [49];

    int checks = 0;
    int failures = 0;

    function automatic logic [MASKLEN-1:0] window(input logic [A_WIDTH-1:0] a);
        logic [MASKLEN-1:0] w;
        w = '0;
        for (int k = 0; k < 49; k++)
            w[MASKLEN-1-8*k -: 8] = img[int'(a) + (k / 7) * W + (k % 7)];
        return w;
    endfunction

    // DRAM window port: data for a sampled ren appears the following cycle.
    always @(posedge clk) begin
        if (bus.ren) bus.rdata <= window(bus.raddr);
        else         bus.rdata <= '0;
    end

    task automatic load_tpl();
        logic [MASKLEN-1:0] t;
        t = '0;
        for (int k = 0; k < 49; k++) t[MASKLEN-1-8*k -: 8] = tpl[k];
        bus.template = t;
    endtask

    task automatic fill(input int img_lo, input int img_hi, input int tpl_lo, input int tpl_hi);
        for (int i = 0; i < W*H; i++) img[i] = 8'($urandom_range(img_hi, img_lo));
        for (int k = 0; k < 49; k++) tpl[k] = 8'($urandom_range(tpl_hi, tpl_lo));
        load_tpl();
    endtask

    task automatic ref_best(output int s, output int a);
        int acc, p, q;
        s = 1 << 30;
        a = 0;
        for (int y = 0; y < YN; y++)
            for (int x = 0; x < XN; x++) begin
                acc = 0;
                for (int k = 0; k < 49; k++) begin
                    p = int'(img[(y + k / 7) * W + x + k % 7]);
                    q = int'(tpl[k]);
                    acc += (p > q) ? p - q : q - p;
                end
                if (acc < s) begin
                    s = acc;
                    a = y * W + x;
                end
            end
    endtask

    int ren_cnt, done_cnt, first_ren, last_ren, done_cyc, busy_fall, addr_errs;
    int done_sad, done_addr, end_sad, end_addr;
    logic busy_at1, timed_out;
    int addrs [$];

    task automatic run_scan(input int mid_start);
        int c;
        logic prev_busy;
        ren_cnt = 0; done_cnt = 0; first_ren = -1; last_ren = -1; done_cyc = -1;
        busy_fall = -1; addr_errs = 0; done_sad = -1; done_addr = -1;
        busy_at1 = 1'b0; timed_out = 1'b0; prev_busy = 1'b0;
        addrs.delete();
        @(negedge clk); bus.start = 1'b1;
        @(negedge clk); bus.start = 1'b0; c = 1;
        forever begin
            if (c == 1) busy_at1 = bus.busy;
            if (bus.ren) begin
                if (first_ren < 0) first_ren = c;
                last_ren = c;
                if (int'(bus.raddr) != (ren_cnt / XN) * W + ren_cnt % XN) addr_errs++;
                addrs.push_back(int'(bus.raddr));
                ren_cnt++;
            end
            if (bus.done) begin
                done_cnt++;
                done_cyc  = c;
                done_sad  = int'(bus.best_sad);
                done_addr = int'(bus.best_addr);
            end
            if (prev_busy && !bus.busy && busy_fall < 0) busy_fall = c;
            prev_busy = bus.busy;
            if (busy_fall >= 0 && c >= busy_fall + 3) break;
            if (c >= 1000) begin timed_out = 1'b1; break; end
            bus.start = (c == mid_start);
            @(negedge clk); c++;
        end
        bus.start = 1'b0;
        end_sad  = int'(bus.best_sad);
        end_addr = int'(bus.best_addr);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (bus.ren !== 1'b0) begin failures++; $display("FAIL reset_ren: got %b expected 0", bus.ren); end
        checks++; if (bus.raddr !== '0) begin failures++; $display("FAIL reset_raddr: got %0d expected 0", bus.raddr); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", bus.done); end
        checks++; if (bus.best_sad !== 14'd16383) begin failures++; $display("FAIL reset_best_sad: got %0d expected 16383", bus.best_sad); end
        checks++; if (bus.best_addr !== '0) begin failures++; $display("FAIL reset_best_addr: got %0d expected 0", bus.best_addr); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_address_sequence();
        int es, ea;
        fill(0, 255, 0, 255);
        ref_best(es, ea);
        run_scan(0);
        checks++; if (timed_out !== 1'b0) begin failures++; $display("FAIL seq_timeout: scan did not finish within budget"); end
        checks++; if (busy_at1 !== 1'b1) begin failures++; $display("FAIL seq_busy_cycle1: got %b expected 1", busy_at1); end
        checks++; if (first_ren != 1) begin failures++; $display("FAIL seq_first_ren: got cycle %0d expected 1", first_ren); end
        checks++; if (ren_cnt != NPOS) begin failures++; $display("FAIL seq_ren_count: got %0d expected %0d", ren_cnt, NPOS); end
        checks++; if (last_ren - first_ren + 1 != ren_cnt) begin failures++; $display("FAIL seq_no_bubbles: span %0d count %0d", last_ren - first_ren + 1, ren_cnt); end
        checks++; if (addr_errs != 0) begin failures++; $display("FAIL seq_raster_order: got %0d bad addresses expected 0", addr_errs); end
        checks++; if (addrs.size() <= XN || addrs[XN] != W) begin failures++; $display("FAIL seq_row_wrap: got %0d expected %0d", (addrs.size() > XN) ? addrs[XN] : -1, W); end
        checks++; if (addrs.size() == 0 || addrs[addrs.size()-1] != LAST_A) begin failures++; $display("FAIL seq_last_addr: got %0d expected %0d", (addrs.size() > 0) ? addrs[addrs.size()-1] : -1, LAST_A); end
        checks++; if (done_cnt != 1) begin failures++; $display("FAIL seq_done_count: got %0d expected 1", done_cnt); end
        checks++; if (done_cyc != last_ren + 4) begin failures++; $display("FAIL seq_done_latency: got cycle %0d expected %0d", done_cyc, last_ren + 4); end
        checks++; if (busy_fall != last_ren + 5) begin failures++; $display("FAIL seq_busy_fall: got cycle %0d expected %0d", busy_fall, last_ren + 5); end
        checks++; if (done_sad != es) begin failures++; $display("FAIL seq_best_sad: got %0d expected %0d", done_sad, es); end
        checks++; if (done_addr != ea) begin failures++; $display("FAIL seq_best_addr: got %0d expected %0d", done_addr, ea); end
        checks++; if (end_sad != es || end_addr != ea) begin failures++; $display("FAIL seq_hold_idle: got %0d/%0d expected %0d/%0d", end_sad, end_addr, es, ea); end
    endtask

    task automatic test_random();
        int es, ea;
        for (int r = 0; r < 4; r++) begin
            if (r % 2 == 0) fill(0, 255, 0, 255);
            else            fill(0, 3, 0, 3);
            ref_best(es, ea);
            run_scan(0);
            checks++; if (timed_out !== 1'b0) begin failures++; $display("FAIL rand%0d_timeout: scan did not finish within budget", r); end
            checks++; if (done_sad != es) begin failures++; $display("FAIL rand%0d_best_sad: got %0d expected %0d", r, done_sad, es); end
            checks++; if (done_addr != ea) begin failures++; $display("FAIL rand%0d_best_addr: got %0d expected %0d", r, done_addr, ea); end
        end
    endtask

    task automatic test_tie();
        fill(255, 255, 255, 255);
        run_scan(0);
        checks++; if (done_sad != 0) begin failures++; $display("FAIL tie_best_sad: got %0d expected 0", done_sad); end
        checks++; if (done_addr != 0) begin failures++; $display("FAIL tie_best_addr: got %0d expected 0", done_addr); end
    endtask

    task automatic test_located();
        fill(0, 0, 0, 0);
        for (int k = 0; k < 49; k++) begin
            tpl[k] = 8'(k + 1);
            img[(4 + k / 7) * W + 10 + k % 7] = 8'(k + 1);
        end
        load_tpl();
        run_scan(0);
        checks++; if (done_sad != 0) begin failures++; $display("FAIL located_best_sad: got %0d expected 0", done_sad); end
        checks++; if (done_addr != 4 * W + 10) begin failures++; $display("FAIL located_best_addr: got %0d expected %0d", done_addr, 4 * W + 10); end
    endtask

    task automatic test_max_sad();
        fill(0, 0, 255, 255);
        run_scan(0);
        checks++; if (done_sad != 12495) begin failures++; $display("FAIL max_best_sad: got %0d expected 12495", done_sad); end
        checks++; if (done_addr != 0) begin failures++; $display("FAIL max_best_addr: got %0d expected 0", done_addr); end
    endtask

    task automatic test_ignored_start();
        int es, ea;
        fill(0, 255, 0, 255);
        ref_best(es, ea);
        run_scan(40);
        checks++; if (ren_cnt != NPOS) begin failures++; $display("FAIL ignstart_ren_count: got %0d expected %0d", ren_cnt, NPOS); end
        checks++; if (done_cnt != 1) begin failures++; $display("FAIL ignstart_done_count: got %0d expected 1", done_cnt); end
        checks++; if (done_sad != es || done_addr != ea) begin failures++; $display("FAIL ignstart_result: got %0d/%0d expected %0d/%0d", done_sad, done_addr, es, ea); end
    endtask

    task automatic test_reset_mid_scan();
        int es, ea;
        fill(0, 255, 0, 255);
        ref_best(es, ea);
        @(negedge clk); bus.start = 1'b1;
        @(negedge clk); bus.start = 1'b0;
        repeat (60) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (bus.ren !== 1'b0) begin failures++; $display("FAIL midrst_ren: got %b expected 0", bus.ren); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL midrst_busy: got %b expected 0", bus.busy); end
        checks++; if (bus.best_sad !== 14'd16383) begin failures++; $display("FAIL midrst_best_sad: got %0d expected 16383", bus.best_sad); end
        checks++; if (bus.best_addr !== '0) begin failures++; $display("FAIL midrst_best_addr: got %0d expected 0", bus.best_addr); end
        @(negedge clk); rst = 1'b0;
        repeat (2) @(negedge clk);
        run_scan(0);
        checks++; if (addrs.size() == 0 || addrs[0] != 0) begin failures++; $display("FAIL midrst_restart_addr: got %0d expected 0", (addrs.size() > 0) ? addrs[0] : -1); end
        checks++; if (ren_cnt != NPOS) begin failures++; $display("FAIL midrst_ren_count: got %0d expected %0d", ren_cnt, NPOS); end
        checks++; if (done_sad != es || done_addr != ea) begin failures++; $display("FAIL midrst_result: got %0d/%0d expected %0d/%0d", done_sad, done_addr, es, ea); end
    endtask

    initial begin
        bus.start    = 1'b0;
        bus.template = '0;
        test_reset();
        test_address_sequence();
        test_random();
        test_tie();
        test_located();
        test_max_sad();
        test_ignored_start();
        test_reset_mid_scan();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
